// File: rtl/gol_ram_arbiter_if.sv
// Requester and bank-RAM signal bundle for gol_ram_arbiter.
//   slave  : arbiter side. It takes the video, engine and host requests,
//            returns grants and read data, and drives both bank RAM ports.
//   master : requester/RAM side. It is the mirror image of slave.
// Fields: ram_select; vid_*; eng_*; host_*; bank0_*/bank1_* address, write
// enable, write data and read data.
interface gol_ram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 4
);
  logic              ram_select;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_rvalid;

  logic              eng_req;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic              eng_gnt;
  logic [DATA_W-1:0] eng_rdata;
  logic              eng_rvalid;

  logic              host_req;
  logic              host_we;
  logic [1:0]        host_bsel;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic [ADDR_W-1:0] bank0_addr;
  logic              bank0_we;
  logic [DATA_W-1:0] bank0_din;
  logic [DATA_W-1:0] bank0_dout;
  logic [ADDR_W-1:0] bank1_addr;
  logic              bank1_we;
  logic [DATA_W-1:0] bank1_din;
  logic [DATA_W-1:0] bank1_dout;

  modport slave (
    input  ram_select,
    input  vid_req, vid_addr,
    output vid_rdata, vid_rvalid,
    input  eng_req, eng_we, eng_addr, eng_wdata,
    output eng_gnt, eng_rdata, eng_rvalid,
    input  host_req, host_we, host_bsel, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output bank0_addr, bank0_we, bank0_din,
    input  bank0_dout,
    output bank1_addr, bank1_we, bank1_din,
    input  bank1_dout
  );

  modport master (
    output ram_select,
    output vid_req, vid_addr,
    input  vid_rdata, vid_rvalid,
    output eng_req, eng_we, eng_addr, eng_wdata,
    input  eng_gnt, eng_rdata, eng_rvalid,
    output host_req, host_we, host_bsel, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  bank0_addr, bank0_we, bank0_din,
    output bank0_dout,
    input  bank1_addr, bank1_we, bank1_din,
    output bank1_dout
  );
endinterface

// File: rtl/gol_ram_arbiter.sv
// gol_ram_arbiter: shares the two single-port cell banks among three
// requesters: video scanout, the GoL update engine and the host loader.
// The display bank is ram_select and the update bank is ~ram_select.
// Display bank priority : video > host.
// Update bank priority  : engine > host. When the host has waited
//                         STARVE_MAX cycles, host > engine.
// Grants and bank drive are combinational in the grant cycle. Read data
// returns one cycle later and is routed by a per-bank registered tag.
// Ports:
//   clk   : system clock
//   rst_n : synchronous reset, active low
//   bus   : gol_ram_arbiter_if.slave (requesters and bank RAM ports)
module gol_ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 4,
  parameter int STARVE_MAX = 255
) (
  input logic               clk,
  input logic               rst_n,
  gol_ram_arbiter_if.slave  bus
);

  localparam logic [0:0] H_IDLE = 1'b0;
  localparam logic [0:0] H_B1   = 1'b1;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_VID  = 2'd1;
  localparam logic [1:0] SRC_ENG  = 2'd2;
  localparam logic [1:0] SRC_HOST = 2'd3;

  logic [0:0]        h_state;
  logic [7:0]        starve_cnt;
  logic              starve_max;

  logic              host_active;
  logic              dual_wr;
  logic              host_bank;
  logic              host_on_disp;
  logic              eng_win;
  logic              host_win;
  logic              host_done;

  logic [ADDR_W-1:0] addr_q [2];
  logic [ADDR_W-1:0] addr_n [2];
  logic [DATA_W-1:0] din_q  [2];
  logic [DATA_W-1:0] din_n  [2];
  logic              we_n   [2];
  logic [1:0]        tag_q  [2];
  logic [1:0]        tag_n  [2];
  logic [DATA_W-1:0] dout   [2];

  assign dout[0]    = bus.bank0_dout;
  assign dout[1]    = bus.bank1_dout;
  assign starve_max = (starve_cnt == 8'(STARVE_MAX));

  // Host-side arbitration. The second phase of a dual write always targets
  // bank1, and the first phase or any single access targets the bank that
  // bsel names. A read with bsel=11 uses bank0.
  always_comb begin
    host_active  = bus.host_req && (bus.host_bsel != 2'b00);
    dual_wr      = (bus.host_bsel == 2'b11) && bus.host_we;
    host_bank    = (h_state == H_B1) || (bus.host_bsel == 2'b10);
    host_on_disp = (host_bank == bus.ram_select);
    eng_win      = rst_n && bus.eng_req &&
                   !(host_active && !host_on_disp && starve_max);
    host_win     = rst_n && host_active &&
                   (host_on_disp ? !bus.vid_req : !eng_win);
    // A bsel=00 request completes at once. The first phase of a dual write
    // wins a bank but does not complete the transaction.
    host_done    = rst_n && bus.host_req &&
                   (!host_active || (host_win && !((h_state == H_IDLE) && dual_wr)));
  end

  assign bus.eng_gnt  = eng_win;
  assign bus.host_gnt = host_done;

  // Per-bank drive. The winners are mutually exclusive on each bank. An idle
  // bank keeps its last address and data with we low.
  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      addr_n[b] = addr_q[b];
      din_n[b]  = din_q[b];
      we_n[b]   = 1'b0;
      tag_n[b]  = SRC_NONE;
      if (rst_n && bus.vid_req && (bus.ram_select == b[0])) begin
        addr_n[b] = bus.vid_addr;
        tag_n[b]  = SRC_VID;
      end else if (eng_win && (bus.ram_select != b[0])) begin
        addr_n[b] = bus.eng_addr;
        din_n[b]  = bus.eng_wdata;
        we_n[b]   = bus.eng_we;
        tag_n[b]  = bus.eng_we ? SRC_NONE : SRC_ENG;
      end else if (host_win && (host_bank == b[0])) begin
        addr_n[b] = bus.host_addr;
        din_n[b]  = bus.host_wdata;
        we_n[b]   = bus.host_we;
        tag_n[b]  = bus.host_we ? SRC_NONE : SRC_HOST;
      end
    end
  end

  assign bus.bank0_addr = addr_n[0];
  assign bus.bank0_we   = we_n[0];
  assign bus.bank0_din  = din_n[0];
  assign bus.bank1_addr = addr_n[1];
  assign bus.bank1_we   = we_n[1];
  assign bus.bank1_din  = din_n[1];

  // Read return uses the tag captured in the grant cycle, not the current
  // ram_select. A flip between grant and return therefore cannot misroute.
  always_comb begin
    bus.vid_rvalid  = 1'b0;
    bus.vid_rdata   = '0;
    bus.eng_rvalid  = 1'b0;
    bus.eng_rdata   = '0;
    bus.host_rvalid = 1'b0;
    bus.host_rdata  = '0;
    for (int unsigned b = 0; b < 2; b++) begin
      case (tag_q[b])
        SRC_VID: begin
          bus.vid_rvalid = 1'b1;
          bus.vid_rdata  = dout[b];
        end
        SRC_ENG: begin
          bus.eng_rvalid = 1'b1;
          bus.eng_rdata  = dout[b];
        end
        SRC_HOST: begin
          bus.host_rvalid = 1'b1;
          bus.host_rdata  = dout[b];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_state    <= H_IDLE;
      starve_cnt <= '0;
      for (int unsigned b = 0; b < 2; b++) begin
        addr_q[b] <= '0;
        din_q[b]  <= '0;
        tag_q[b]  <= SRC_NONE;
      end
    end else begin
      for (int unsigned b = 0; b < 2; b++) begin
        addr_q[b] <= addr_n[b];
        din_q[b]  <= din_n[b];
        tag_q[b]  <= tag_n[b];
      end
      // The wait count holds while a dual-write phase is in progress, so the
      // second phase inherits the waiting time already accrued.
      if (!bus.host_req || host_done)
        starve_cnt <= '0;
      else if (!host_win && !starve_max)
        starve_cnt <= starve_cnt + 8'd1;

      if ((h_state == H_IDLE) && host_win && dual_wr)
        h_state <= H_B1;
      else if (host_done)
        h_state <= H_IDLE;
    end
  end

endmodule
